// File: rtl/eros_obi2axil.sv
// eros_obi2axil: OBI slave to AXI4-Lite master bridge, one transaction outstanding.
// Request fields are captured on grant; the response is a single rvalid_o pulse.
module eros_obi2axil #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter logic [2:0]  AXI_PROT   = 3'b000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   m_axi_awaddr,
  output logic [2:0]              m_axi_awprot,
  output logic                    m_axi_awvalid,
  input  logic                    m_axi_awready,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  input  logic [1:0]              m_axi_bresp,
  input  logic                    m_axi_bvalid,
  output logic                    m_axi_bready,
  output logic [ADDR_WIDTH-1:0]   m_axi_araddr,
  output logic [2:0]              m_axi_arprot,
  output logic                    m_axi_arvalid,
  input  logic                    m_axi_arready,
  input  logic [DATA_WIDTH-1:0]   m_axi_rdata,
  input  logic [1:0]              m_axi_rresp,
  input  logic                    m_axi_rvalid,
  output logic                    m_axi_rready
);
  typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_e;
  state_e                  state_q;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic                    we_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic [DATA_WIDTH-1:0]   wdata_q, rdata_q;
  logic                    err_q, aw_done_q, w_done_q;
  logic                    aw_done_d, w_done_d;
  // A channel counts as done once its valid has seen ready; valid is low afterwards.
  assign aw_done_d     = aw_done_q | m_axi_awready;
  assign w_done_d      = w_done_q | m_axi_wready;
  assign gnt_o         = (state_q == IDLE) & req_i;
  assign m_axi_awvalid = (state_q == WR_REQ) & we_q & ~aw_done_q;
  assign m_axi_wvalid  = (state_q == WR_REQ) & we_q & ~w_done_q;
  assign m_axi_bready  = (state_q == WR_RESP);
  assign m_axi_arvalid = (state_q == RD_REQ) & ~we_q;
  assign m_axi_rready  = (state_q == RD_DATA);
  assign rvalid_o      = (state_q == RESP);
  assign rdata_o       = rdata_q;
  assign err_o         = err_q;
  assign m_axi_awaddr  = addr_q;
  assign m_axi_araddr  = addr_q;
  assign m_axi_wdata   = wdata_q;
  assign m_axi_wstrb   = be_q;
  assign m_axi_awprot  = AXI_PROT;
  assign m_axi_arprot  = AXI_PROT;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      we_q      <= 1'b0;
      be_q      <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (gnt_o) begin
          addr_q    <= addr_i;
          we_q      <= we_i;
          be_q      <= be_i;
          wdata_q   <= wdata_i;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
          state_q   <= we_i ? WR_REQ : RD_REQ;
        end
        WR_REQ: begin
          aw_done_q <= aw_done_d;
          w_done_q  <= w_done_d;
          if (aw_done_d && w_done_d) state_q <= WR_RESP;
        end
        WR_RESP: if (m_axi_bvalid) begin
          err_q   <= (m_axi_bresp != 2'b00);
          rdata_q <= '0;
          state_q <= RESP;
        end
        RD_REQ: if (m_axi_arready) state_q <= RD_DATA;
        RD_DATA: if (m_axi_rvalid) begin
          err_q   <= (m_axi_rresp != 2'b00);
          rdata_q <= m_axi_rdata;
          state_q <= RESP;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_eros_obi2axil.sv
// tb_eros_obi2axil: directed scenario bench for the OBI to AXI4-Lite bridge.
`timescale 1ns/1ps
module tb_eros_obi2axil;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, gnt, rvalid, err;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0]  be = '0, wstrb;
  logic [31:0] awaddr, araddr, axi_wdata, axi_rdata = '0;
  logic [2:0]  awprot, arprot;
  logic        awvalid, awready = 1'b0, wvalid, wready = 1'b0;
  logic [1:0]  bresp = '0, rresp = '0;
  logic        bvalid = 1'b0, bready, arvalid, arready = 1'b0;
  logic        axi_rvalid = 1'b0, rready;
  int          tests = 0, fails = 0;

  eros_obi2axil dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .gnt_o(gnt), .addr_i(addr), .we_i(we),
    .be_i(be), .wdata_i(wdata), .rvalid_o(rvalid), .rdata_o(rdata), .err_o(err),
    .m_axi_awaddr(awaddr), .m_axi_awprot(awprot), .m_axi_awvalid(awvalid), .m_axi_awready(awready),
    .m_axi_wdata(axi_wdata), .m_axi_wstrb(wstrb), .m_axi_wvalid(wvalid), .m_axi_wready(wready),
    .m_axi_bresp(bresp), .m_axi_bvalid(bvalid), .m_axi_bready(bready),
    .m_axi_araddr(araddr), .m_axi_arprot(arprot), .m_axi_arvalid(arvalid), .m_axi_arready(arready),
    .m_axi_rdata(axi_rdata), .m_axi_rresp(rresp), .m_axi_rvalid(axi_rvalid), .m_axi_rready(rready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    #3;
    tests++; if ({awvalid, wvalid, bready, arvalid, rready} !== 5'b0) begin fails++; $display("FAIL reset_axi: got %b want 00000", {awvalid, wvalid, bready, arvalid, rready}); end
    tests++; if ({rvalid, err} !== 2'b0) begin fails++; $display("FAIL reset_obi: got %b want 00", {rvalid, err}); end
    tests++; if (rdata !== 32'h0 || awaddr !== 32'h0) begin fails++; $display("FAIL reset_regs: rdata %h awaddr %h want 0", rdata, awaddr); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_write_basic();
    addr = 32'h1000_0040; wdata = 32'hDEAD_BEEF; be = 4'hF; we = 1'b1; req = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00;
    #1;
    tests++; if (gnt !== 1'b1) begin fails++; $display("FAIL wr_gnt: got %b want 1", gnt); end
    tick();
    req = 1'b0; we = 1'b0; addr = '0; wdata = '0; be = '0;
    #1;
    tests++; if ({awvalid, wvalid} !== 2'b11) begin fails++; $display("FAIL wr_c1_valid: got %b want 11", {awvalid, wvalid}); end
    tests++; if (awaddr !== 32'h1000_0040) begin fails++; $display("FAIL wr_awaddr: got %h want 10000040", awaddr); end
    tests++; if (axi_wdata !== 32'hDEAD_BEEF || wstrb !== 4'hF) begin fails++; $display("FAIL wr_wdata: got %h/%h want deadbeef/f", axi_wdata, wstrb); end
    tests++; if (awprot !== 3'b000 || arprot !== 3'b000) begin fails++; $display("FAIL wr_prot: got %b/%b want 000", awprot, arprot); end
    tick();
    tests++; if ({awvalid, wvalid, bready} !== 3'b001) begin fails++; $display("FAIL wr_c2: got %b want 001", {awvalid, wvalid, bready}); end
    tick();
    tests++; if ({rvalid, err} !== 2'b10 || rdata !== 32'h0) begin fails++; $display("FAIL wr_c3_resp: rvalid/err %b rdata %h want 10/0", {rvalid, err}, rdata); end
    tick();
    tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL wr_c4_pulse: got %b want 0", rvalid); end
    awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
  endtask

  task automatic test_read_delay();
    addr = 32'h1000_0080; we = 1'b0; req = 1'b1; arready = 1'b0;
    #1;
    tests++; if (gnt !== 1'b1) begin fails++; $display("FAIL rd_gnt: got %b want 1", gnt); end
    tick();
    req = 1'b0; addr = '0;
    for (int i = 1; i <= 5; i++) begin
      tests++; if (arvalid !== 1'b1 || araddr !== 32'h1000_0080) begin fails++; $display("FAIL rd_ar_hold c%0d: arvalid %b araddr %h want 1/10000080", i, arvalid, araddr); end
      if (i == 5) arready = 1'b1;
      tick();
    end
    arready = 1'b0; axi_rvalid = 1'b1; axi_rdata = 32'h1234_5678; rresp = 2'b00;
    tests++; if ({arvalid, rready} !== 2'b01) begin fails++; $display("FAIL rd_c6: got %b want 01", {arvalid, rready}); end
    tick();
    axi_rvalid = 1'b0; axi_rdata = '0;
    tests++; if (rvalid !== 1'b1 || rdata !== 32'h1234_5678 || err !== 1'b0) begin fails++; $display("FAIL rd_resp: rvalid %b rdata %h err %b want 1/12345678/0", rvalid, rdata, err); end
    tick();
    tests++; if (rvalid !== 1'b0 || rdata !== 32'h1234_5678) begin fails++; $display("FAIL rd_hold: rvalid %b rdata %h want 0/12345678", rvalid, rdata); end
    tick();
    tests++; if (rvalid !== 1'b0) begin fails++; $display("FAIL rd_once: got %b want 0", rvalid); end
  endtask

  task automatic test_write_stall();
    addr = 32'h2000_0004; wdata = 32'h0BAD_F00D; be = 4'h3; we = 1'b1; req = 1'b1;
    #1;
    tests++; if (gnt !== 1'b1) begin fails++; $display("FAIL ws_gnt: got %b want 1", gnt); end
    tick();
    req = 1'b0; we = 1'b0; awready = 1'b1;
    #1;
    tests++; if ({awvalid, wvalid} !== 2'b11) begin fails++; $display("FAIL ws_c1: got %b want 11", {awvalid, wvalid}); end
    tick();
    awready = 1'b0;
    tests++; if ({awvalid, wvalid, bready} !== 3'b010 || wstrb !== 4'h3) begin fails++; $display("FAIL ws_c2: got %b strb %h want 010/3", {awvalid, wvalid, bready}, wstrb); end
    tick();
    wready = 1'b1;
    tests++; if ({wvalid, bready} !== 2'b10 || axi_wdata !== 32'h0BAD_F00D) begin fails++; $display("FAIL ws_c3: got %b data %h want 10/0badf00d", {wvalid, bready}, axi_wdata); end
    tick();
    wready = 1'b0; bvalid = 1'b1; bresp = 2'b11;
    tests++; if ({wvalid, bready} !== 2'b01) begin fails++; $display("FAIL ws_c4: got %b want 01", {wvalid, bready}); end
    tick();
    bvalid = 1'b0; bresp = 2'b00;
    tests++; if ({rvalid, err} !== 2'b11 || rdata !== 32'h0) begin fails++; $display("FAIL ws_err: rvalid/err %b rdata %h want 11/0", {rvalid, err}, rdata); end
    tick();
    tests++; if ({rvalid, err} !== 2'b01) begin fails++; $display("FAIL ws_err_hold: got %b want 01", {rvalid, err}); end
  endtask

  task automatic test_read_err();
    addr = 32'h3000_0000; we = 1'b0; req = 1'b1; arready = 1'b1;
    tick();
    req = 1'b0; axi_rvalid = 1'b1; rresp = 2'b10; axi_rdata = 32'hCAFE_F00D;
    tests++; if (arvalid !== 1'b1 || araddr !== 32'h3000_0000) begin fails++; $display("FAIL re_ar: arvalid %b araddr %h want 1/30000000", arvalid, araddr); end
    tick();
    tests++; if (rready !== 1'b1) begin fails++; $display("FAIL re_rready: got %b want 1", rready); end
    tick();
    tests++; if ({rvalid, err} !== 2'b11 || rdata !== 32'hCAFE_F00D) begin fails++; $display("FAIL re_resp: rvalid/err %b rdata %h want 11/cafef00d", {rvalid, err}, rdata); end
    arready = 1'b0; axi_rvalid = 1'b0; rresp = 2'b00;
    tick();
  endtask

  task automatic test_back_to_back();
    bit done = 1'b0;
    addr = 32'h4000_0010; we = 1'b0; req = 1'b1; arready = 1'b0;
    axi_rvalid = 1'b1; axi_rdata = 32'h55AA_55AA;
    #1;
    tests++; if (gnt !== 1'b1) begin fails++; $display("FAIL bb_gnt0: got %b want 1", gnt); end
    tick();
    for (int k = 0; k < 20 && !done; k++) begin
      if (rvalid) done = 1'b1;
      else begin
        tests++; if (gnt !== 1'b0) begin fails++; $display("FAIL bb_busy_gnt c%0d: got %b want 0", k, gnt); end
        if (k == 2) arready = 1'b1;
        tick();
      end
    end
    tests++; if (!done) begin fails++; $display("FAIL bb_timeout: rvalid %b want 1", rvalid); end
    tests++; if (gnt !== 1'b0 || rdata !== 32'h55AA_55AA) begin fails++; $display("FAIL bb_resp: gnt %b rdata %h want 0/55aa55aa", gnt, rdata); end
    tick();
    addr = 32'h4000_0020; axi_rdata = 32'h0F0F_0F0F;
    #1;
    tests++; if (gnt !== 1'b1) begin fails++; $display("FAIL bb_gnt2: got %b want 1", gnt); end
    tick();
    req = 1'b0;
    tests++; if (arvalid !== 1'b1 || araddr !== 32'h4000_0020) begin fails++; $display("FAIL bb_ar2: arvalid %b araddr %h want 1/40000020", arvalid, araddr); end
    tick(); tick();
    tests++; if (rvalid !== 1'b1 || rdata !== 32'h0F0F_0F0F) begin fails++; $display("FAIL bb_resp2: rvalid %b rdata %h want 1/0f0f0f0f", rvalid, rdata); end
    arready = 1'b0; axi_rvalid = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid();
    addr = 32'h5000_0000; wdata = 32'h1; be = 4'hF; we = 1'b1; req = 1'b1;
    awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
    tick();
    req = 1'b0; we = 1'b0;
    tick();
    tests++; if (bready !== 1'b1) begin fails++; $display("FAIL rm_bready: got %b want 1", bready); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if ({awvalid, wvalid, bready, arvalid, rready, rvalid} !== 6'b0) begin fails++; $display("FAIL rm_async: got %b want 000000", {awvalid, wvalid, bready, arvalid, rready, rvalid}); end
    tests++; if (rdata !== 32'h0 || err !== 1'b0 || awaddr !== 32'h0 || axi_wdata !== 32'h0) begin fails++; $display("FAIL rm_regs: rdata %h err %b awaddr %h wdata %h want 0", rdata, err, awaddr, axi_wdata); end
    bvalid = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    req = 1'b1;
    #1;
    tests++; if (gnt !== 1'b1 || rvalid !== 1'b0) begin fails++; $display("FAIL rm_idle: gnt %b rvalid %b want 1/0", gnt, rvalid); end
    req = 1'b0;
    tick();
    tests++; if ({arvalid, awvalid, bready, rvalid} !== 4'b0) begin fails++; $display("FAIL rm_quiet: got %b want 0000", {arvalid, awvalid, bready, rvalid}); end
    bvalid = 1'b0; awready = 1'b0; wready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write_basic();
    test_read_delay();
    test_write_stall();
    test_read_err();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
